rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle MUL/DIV unit of the RV32IM core. MUL/DIV results are captured into a one-entry holding buffer and drained into a free writeback slot; a starvation counter forces a pipeline stall when no slot appears. A 32-entry scoreboard tracks destination registers of in-flight MUL/DIV ops and raises a hazard stall to the ID stage.

## Interface

- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (32 registers, x0 hard-wired zero)
- STARVE_LIMIT, 4, blocked HOLD cycles before FORCE (≥1)

- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- WB_WRITE_ENABLE  in  1  pipeline writeback request
- WB_WRITE_ADDR  in  ADDR_WIDTH  pipeline writeback destination
- WB_WRITE_DATA  in  DATA_WIDTH  pipeline writeback data
- MD_VALID  in  1  MUL/DIV result valid
- MD_ADDR  in  ADDR_WIDTH  MUL/DIV result destination
- MD_DATA  in  DATA_WIDTH  MUL/DIV result data
- MD_READY  out  1  buffer accepts result; transfer when MD_VALID & MD_READY
- ISSUE_MD  in  1  ID dispatches a MUL/DIV op this cycle
- ISSUE_RD  in  ADDR_WIDTH  destination of the dispatched op
- CHECK_ADDR1, CHECK_ADDR2, CHECK_RD  in  ADDR_WIDTH each  ID-stage rs1, rs2, rd
- HAZARD_STALL  out  1  an ID operand or rd is scoreboard-busy
- PIPE_STALL  out  1  freeze front end so a bubble reaches WB
- RF_WRITE_ENABLE, RF_WRITE_ADDR, RF_WRITE_DATA  out  1/ADDR_WIDTH/DATA_WIDTH  to register file write port

## Operation

- Slot free: WB_WRITE_ENABLE==0 or WB_WRITE_ADDR==0.
- Write port mux (combinational): WB slot not free → pass WB request unchanged; else state HOLD/FORCE → present buffer (enable 1); else enable 0, addr 0, data 0.
- FSM states EMPTY, HOLD, FORCE:
  - EMPTY: MD_READY=1. MD_VALID with MD_ADDR≠0 → capture addr/data, counter=0, → HOLD. MD_ADDR==0 → accept and discard, stay EMPTY.
  - HOLD: MD_READY=0. Slot free → drain, → EMPTY. Else counter+1; counter reaching STARVE_LIMIT → FORCE.
  - FORCE: MD_READY=0, PIPE_STALL=1. Slot free → drain, → EMPTY.
- No accept in the drain cycle; MD_READY returns the cycle after drain.
- Scoreboard busy[31:0], busy[0] never set. ISSUE_MD & ISSUE_RD≠0 sets bit; drain clears bit of buffer addr. Same register set and cleared in one cycle → set wins. Setting an already-set bit: no effect (no counting).
- HAZARD_STALL = busy[CHECK_ADDR1] | busy[CHECK_ADDR2] | busy[CHECK_RD] (covers RAW and WAW); combinational from registered busy.

## Timing

- Reset (RESET high at an edge): state EMPTY, counter 0, busy all 0, buffer 0. While RESET high: RF_WRITE_ENABLE=0, MD_READY=0, PIPE_STALL=0; HAZARD_STALL=0 after the reset edge.
- Accept at edge E0 → earliest RF write at E1 (buffer drives port in cycle E0..E1); minimum latency 1 cycle.
- Busy bit clears at drain edge; HAZARD_STALL drops in the following cycle. Register file has no write-through: dependent read valid from the cycle after drain.
- Blocked continuously: HOLD for STARVE_LIMIT cycles, FORCE entered at the next edge; PIPE_STALL held until drain edge, deasserts the cycle after.
- WB priority absolute: a WB write in the drain-eligible cycle is never delayed or dropped.
- RESET mid-HOLD/FORCE: buffered result discarded, no RF write, all busy bits cleared.

## Test plan

- Reset: RESET=1 two cycles with MD_VALID=1 → RF_WRITE_ENABLE=0, MD_READY=0; after release MD_READY=1, HAZARD_STALL=0, PIPE_STALL=0.
- Free slot: ISSUE_MD rd=5; CHECK_ADDR1=5 → HAZARD_STALL=1; MD result x5=42 with WB idle → RF writes x5=42 next edge, HAZARD_STALL=0 cycle after, reg_file reads 42.
- Conflict: WB writing x1=7 each cycle while MD returns x3=100 → RF gets x1=7 only; WB drops enable → x3=100 written that edge.
- x0 slot: WB_WRITE_ENABLE=1, WB_WRITE_ADDR=0, buffer holds x4=9 → RF writes x4=9; x0 reads 0.
- Starvation: STARVE_LIMIT=4, WB busy continuously → PIPE_STALL=1 after 4 blocked cycles; WB idle one cycle → drain, PIPE_STALL=0 next cycle, MD_READY=1.
- Set/clear collision and reset: drain x6 while ISSUE_MD rd=6 → busy[6] stays 1; RESET during HOLD → no write, busy all 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback stage always has priority, and MUL/DIV
// results wait in a one-entry buffer until a free slot appears or starvation stalls the pipe.
module rf_write_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,

    input  logic                  i_wb_write_enable,
    input  logic [ADDR_WIDTH-1:0] i_wb_write_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_write_data,

    input  logic                  i_md_valid,
    input  logic [ADDR_WIDTH-1:0] i_md_addr,
    input  logic [DATA_WIDTH-1:0] i_md_data,
    output logic                  o_md_ready,

    input  logic                  i_issue_md,
    input  logic [ADDR_WIDTH-1:0] i_issue_rd,
    input  logic [ADDR_WIDTH-1:0] i_check_addr1,
    input  logic [ADDR_WIDTH-1:0] i_check_addr2,
    input  logic [ADDR_WIDTH-1:0] i_check_rd,
    output logic                  o_hazard_stall,
    output logic                  o_pipe_stall,

    output logic                  o_rf_write_enable,
    output logic [ADDR_WIDTH-1:0] o_rf_write_addr,
    output logic [DATA_WIDTH-1:0] o_rf_write_data
);

    localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StHold  = 2'd1;
    localparam logic [1:0] StForce = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic [NUM_REGS-1:0]   r_busy;

    logic [1:0]            w_state_next;
    logic [CNT_WIDTH-1:0]  w_cnt_next;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [ADDR_WIDTH-1:0] w_buf_addr_next;
    logic [DATA_WIDTH-1:0] w_buf_data_next;
    logic [NUM_REGS-1:0]   w_busy_next;
    logic                  w_slot_free;
    logic                  w_buf_full;
    logic                  w_drain;
    logic                  w_accept;

    // Writes to x0 are architecturally dead, so such a WB cycle can carry the buffered result.
    assign w_slot_free = !i_wb_write_enable || (i_wb_write_addr == '0);
    assign w_buf_full  = (r_state == StHold) || (r_state == StForce);
    assign w_drain     = w_buf_full && w_slot_free && !i_reset;
    assign w_accept    = (r_state == StEmpty) && i_md_valid && !i_reset;
    assign w_cnt_inc   = r_cnt + CNT_WIDTH'(1);

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_buf_addr_next = r_buf_addr;
        w_buf_data_next = r_buf_data;
        case (r_state)
            StEmpty: begin
                if (w_accept && (i_md_addr != '0)) begin
                    w_state_next    = StHold;
                    w_cnt_next      = '0;
                    w_buf_addr_next = i_md_addr;
                    w_buf_data_next = i_md_data;
                end
            end
            StHold: begin
                if (w_slot_free) begin
                    w_state_next = StEmpty;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == CNT_WIDTH'(STARVE_LIMIT)) begin
                        w_state_next = StForce;
                    end
                end
            end
            StForce: begin
                if (w_slot_free) begin
                    w_state_next = StEmpty;
                end
            end
            default: begin
                w_state_next = StEmpty;
            end
        endcase
    end

    // A fresh issue to the register being drained must win, so the set is applied last.
    always_comb begin
        w_busy_next = r_busy;
        if (w_drain) begin
            w_busy_next[r_buf_addr] = 1'b0;
        end
        if (i_issue_md && (i_issue_rd != '0)) begin
            w_busy_next[i_issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StEmpty;
            r_cnt      <= '0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_busy     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_buf_addr <= w_buf_addr_next;
            r_buf_data <= w_buf_data_next;
            r_busy     <= w_busy_next;
        end
    end

    always_comb begin
        o_rf_write_enable = 1'b0;
        o_rf_write_addr   = '0;
        o_rf_write_data   = '0;
        if (!i_reset) begin
            if (!w_slot_free) begin
                o_rf_write_enable = 1'b1;
                o_rf_write_addr   = i_wb_write_addr;
                o_rf_write_data   = i_wb_write_data;
            end else if (w_buf_full) begin
                o_rf_write_enable = 1'b1;
                o_rf_write_addr   = r_buf_addr;
                o_rf_write_data   = r_buf_data;
            end
        end
    end

    assign o_md_ready     = (r_state == StEmpty) && !i_reset;
    assign o_pipe_stall   = (r_state == StForce) && !i_reset;
    assign o_hazard_stall = r_busy[i_check_addr1] | r_busy[i_check_addr2] | r_busy[i_check_rd];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level reference model of the
// write-port arbiter (pending result, blocked-cycle count, busy set).
module tb_rf_write_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          md_valid;
    logic [AW-1:0] md_addr;
    logic [DW-1:0] md_data;
    logic          md_ready;
    logic          issue_md;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] chk1, chk2, chk_rd;
    logic          hazard;
    logic          pipe_stall;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit            m_init = 1'b0;
    bit            m_full = 1'b0;
    int            m_blocked = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit            m_busy [32];

    // Register file as seen by the bench, fed only from the DUT write port
    logic [DW-1:0] shadow_rf [32];

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(LIMIT)
    ) u_dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_wb_write_enable(wb_en),
        .i_wb_write_addr  (wb_addr),
        .i_wb_write_data  (wb_data),
        .i_md_valid       (md_valid),
        .i_md_addr        (md_addr),
        .i_md_data        (md_data),
        .o_md_ready       (md_ready),
        .i_issue_md       (issue_md),
        .i_issue_rd       (issue_rd),
        .i_check_addr1    (chk1),
        .i_check_addr2    (chk2),
        .i_check_rd       (chk_rd),
        .o_hazard_stall   (hazard),
        .o_pipe_stall     (pipe_stall),
        .o_rf_write_enable(rf_we),
        .o_rf_write_addr  (rf_addr),
        .o_rf_write_data  (rf_data)
    );

    always @(posedge clk) begin
        if (rf_we && rf_addr != '0) shadow_rf[rf_addr] <= rf_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the coming edge.
    task automatic model_cycle();
        bit            slot_free;
        bit            exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        slot_free = !wb_en || (wb_addr == '0);
        exp_we = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        if (!reset) begin
            if (!slot_free) begin
                exp_we = 1'b1;
                exp_addr = wb_addr;
                exp_data = wb_data;
            end else if (m_full) begin
                exp_we = 1'b1;
                exp_addr = m_addr;
                exp_data = m_data;
            end
        end
        check("rf_we", 64'(rf_we), 64'(exp_we));
        check("rf_addr", 64'(rf_addr), 64'(exp_addr));
        check("rf_data", 64'(rf_data), 64'(exp_data));
        check("md_ready", 64'(md_ready), 64'(!reset && !m_full));
        check("pipe_stall", 64'(pipe_stall), 64'(!reset && m_full && m_blocked >= LIMIT));
        if (m_init) begin
            check("hazard", 64'(hazard), 64'(m_busy[chk1] | m_busy[chk2] | m_busy[chk_rd]));
        end

        if (reset) begin
            m_init = 1'b1;
            m_full = 1'b0;
            m_blocked = 0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            if (m_full && slot_free) begin
                m_busy[m_addr] = 1'b0;
                m_full = 1'b0;
            end else if (m_full) begin
                m_blocked++;
            end else if (md_valid && md_addr != '0) begin
                m_full = 1'b1;
                m_addr = md_addr;
                m_data = md_data;
                m_blocked = 0;
            end
            if (issue_md && issue_rd != '0) m_busy[issue_rd] = 1'b1;
        end
    endtask

    task automatic tick();
        #1;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
        issue_md = 1'b0; issue_rd = '0;
        chk1 = '0; chk2 = '0; chk_rd = '0;
    endtask

    initial begin
        foreach (shadow_rf[i]) shadow_rf[i] = '0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        set_idle();
        @(negedge clk);

        // Reset with a result offered
        reset = 1'b1; md_valid = 1'b1; md_addr = 5'd9; md_data = 32'hdead;
        tick(); tick();
        set_idle();
        tick();

        // Free slot: issue x5, result 42 drains with WB idle
        issue_md = 1'b1; issue_rd = 5'd5; tick();
        set_idle(); chk1 = 5'd5; md_valid = 1'b1; md_addr = 5'd5; md_data = 32'd42; tick();
        set_idle(); chk1 = 5'd5; tick();
        chk1 = 5'd5; tick();
        check("rf_x5", 64'(shadow_rf[5]), 64'd42);

        // Conflict: WB keeps writing x1 while x3 waits
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
        md_valid = 1'b1; md_addr = 5'd3; md_data = 32'd100; tick();
        md_valid = 1'b0; tick(); tick();
        set_idle(); tick();
        check("rf_x1", 64'(shadow_rf[1]), 64'd7);
        check("rf_x3", 64'(shadow_rf[3]), 64'd100);

        // x0 writeback frees the slot
        md_valid = 1'b1; md_addr = 5'd4; md_data = 32'd9; tick();
        set_idle(); wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hffff; tick();
        set_idle(); tick();
        check("rf_x4", 64'(shadow_rf[4]), 64'd9);
        check("rf_x0", 64'(shadow_rf[0]), 64'd0);

        // Starvation into FORCE, then one idle WB cycle drains
        md_valid = 1'b1; md_addr = 5'd2; md_data = 32'h22; tick();
        set_idle(); wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h88;
        for (int i = 0; i < 6; i++) tick();
        set_idle(); tick(); tick();

        // Drain of x6 collides with a new issue to x6
        issue_md = 1'b1; issue_rd = 5'd6; tick();
        set_idle(); md_valid = 1'b1; md_addr = 5'd6; md_data = 32'h66; tick();
        set_idle(); issue_md = 1'b1; issue_rd = 5'd6; chk2 = 5'd6; tick();
        set_idle(); chk2 = 5'd6; tick(); tick();

        // Reset while a result is held
        issue_md = 1'b1; issue_rd = 5'd7; tick();
        set_idle(); md_valid = 1'b1; md_addr = 5'd7; md_data = 32'h77; tick();
        set_idle(); wb_en = 1'b1; wb_addr = 5'd9; chk_rd = 5'd7; tick();
        reset = 1'b1; tick();
        set_idle(); chk_rd = 5'd7; chk1 = 5'd6; tick(); tick();
        check("rf_x7", 64'(shadow_rf[7]), 64'd0);

        // Randomized traffic with varying WB pressure
        for (int blk = 0; blk < 15; blk++) begin
            int p_wb;
            p_wb = (blk % 3 == 0) ? 95 : ((blk % 3 == 1) ? 60 : 20);
            for (int c = 0; c < 200; c++) begin
                reset    = ($urandom_range(0, 63) == 0);
                wb_en    = ($urandom_range(0, 99) < p_wb);
                wb_addr  = AW'($urandom_range(0, 7));
                wb_data  = $urandom;
                md_valid = ($urandom_range(0, 1) == 1);
                md_addr  = AW'($urandom_range(0, 7));
                md_data  = $urandom;
                issue_md = ($urandom_range(0, 9) < 3);
                issue_rd = AW'($urandom_range(0, 7));
                chk1     = AW'($urandom_range(0, 7));
                chk2     = AW'($urandom_range(0, 7));
                chk_rd   = AW'($urandom_range(0, 7));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
